// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register-bank sizing and GPR bank state type for the 8-bit bus CPU
package cpu_pkg;
  localparam int CPU_DATA_W = 8;
  localparam int CPU_NREGS = 16;
  typedef enum logic {CLEAR, RUN} gpr_state_e;
  typedef logic [3:0] reg_addr_t;
endpackage

// File: rtl/gpr_clear_seq.sv
// gpr_clear_seq: post-reset sequencer that zeroes every bank entry once and then raises ready
module gpr_clear_seq
  import cpu_pkg::*;
#(
  parameter int NREGS = CPU_NREGS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);
  gpr_state_e state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic ready_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == CLEAR) begin
      clr_idx_q <= clr_idx_q + 1'b1;
      if (clr_idx_q == ADDR_W'(NREGS - 1)) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end
  assign ready_o    = ready_q;
  assign clr_we_o   = state_q == CLEAR;
  assign clr_addr_o = clr_idx_q;
endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: GPR bank with one write port, two registered write-first read ports and a post-reset clear
// GPR_BANK_ZERO_REG_EN: when defined, register 0 reads as zero and ignores writes
module gpr_bank
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int NREGS = CPU_NREGS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rda_en,
  input  logic [ADDR_W-1:0] rda_addr,
  output logic [DATA_W-1:0] rda_data,
  input  logic              rdb_en,
  input  logic [ADDR_W-1:0] rdb_addr,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe
);
`ifdef GPR_BANK_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  logic clr_we, u_we, we, oe_q;
  logic [ADDR_W-1:0] clr_addr, waddr;
  logic [DATA_W-1:0] wdata, rda_d, rdb_d, rda_q, bus_q;
  logic [DATA_W-1:0] mem_q [NREGS];

  gpr_clear_seq #(.NREGS(NREGS)) u_seq (
    .clk        (clk),
    .reset      (reset),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // dropping r0 writes here also kills the bypass, so r0 stays at its cleared zero
  always_comb begin
    u_we  = ready & wr_en & ~(ZERO_REG && wr_addr == '0);
    we    = clr_we | u_we;
    waddr = clr_we ? clr_addr : wr_addr;
    wdata = clr_we ? '0 : wr_data;
    rda_d = (u_we && rda_addr == wr_addr) ? wr_data : mem_q[rda_addr];
    rdb_d = (u_we && rdb_addr == wr_addr) ? wr_data : mem_q[rdb_addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rda_q <= '0;
      bus_q <= '0;
      oe_q  <= 1'b0;
    end else if (ready) begin
      if (rda_en) rda_q <= rda_d;
      bus_q <= rdb_en ? rdb_d : '0;
      oe_q  <= rdb_en;
    end
  end

  assign rda_data = rda_q;
  assign bus_out  = bus_q;
  assign bus_oe   = oe_q;
endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: vector-table and scoreboard bench for gpr_bank (honours GPR_BANK_ZERO_REG_EN)
module tb_gpr_bank;
`ifdef GPR_BANK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  localparam logic [7:0] Z77 = ZR ? 8'h00 : 8'h77;
  localparam logic [7:0] Z66 = ZR ? 8'h00 : 8'h66;

  typedef struct {
    logic we; logic [3:0] wa; logic [7:0] wd;
    logic ae; logic [3:0] aa;
    logic be; logic [3:0] ba;
    logic [7:0] ea; logic [7:0] eb; logic eo;
    string tag;
  } vec_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic oe; logic rdy; string tag;} exp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic wr_en = 0, rda_en = 0, rdb_en = 0;
  logic [3:0] wr_addr = 0, rda_addr = 0, rdb_addr = 0;
  logic [7:0] wr_data = 0;
  logic ready, bus_oe;
  logic [7:0] rda_data, bus_out;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  vec_t tbl[13];

  gpr_bank dut (
    .clk(clk), .reset(reset), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rda_en(rda_en), .rda_addr(rda_addr), .rda_data(rda_data),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr), .bus_out(bus_out), .bus_oe(bus_oe)
  );

  always #5 clk = ~clk;

  task automatic check_pending();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({rda_data, bus_out, bus_oe, ready} !== {e.a, e.b, e.oe, e.rdy}) begin
        n_fail++;
        $display("FAIL %s: got rda=%h bus=%h oe=%b rdy=%b, expected rda=%h bus=%h oe=%b rdy=%b",
                 e.tag, rda_data, bus_out, bus_oe, ready, e.a, e.b, e.oe, e.rdy);
      end
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic ae, input logic [3:0] aa, input logic be, input logic [3:0] ba,
                      input logic [7:0] ea, input logic [7:0] eb, input logic eo, input logic erdy,
                      input string tag);
    exp_t e;
    @(negedge clk);
    check_pending();
    reset = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rda_en = ae; rda_addr = aa; rdb_en = be; rdb_addr = ba;
    e.a = ea; e.b = eb; e.oe = eo; e.rdy = erdy; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [7:0] ea, input logic erdy, input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, ea, 8'h00, 0, erdy, tag);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 4'(i), 1, 4'(i), 8'h00, 8'h00, 1, 1, tag);
  endtask

  initial begin
    tbl[0]  = '{1, 5, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h00, 0, "wr_r5"};
    tbl[1]  = '{0, 0, 8'h00, 1, 5, 0, 0, 8'hA5, 8'h00, 0, "rda_r5"};
    tbl[2]  = '{0, 0, 8'h00, 0, 0, 1, 5, 8'hA5, 8'hA5, 1, "rdb_r5"};
    tbl[3]  = '{0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00, 0, "rdb_release"};
    tbl[4]  = '{1, 3, 8'h3C, 1, 3, 1, 3, 8'h3C, 8'h3C, 1, "write_first_both"};
    tbl[5]  = '{0, 0, 8'h00, 0, 0, 0, 0, 8'h3C, 8'h00, 0, "hold_a"};
    tbl[6]  = '{1, 9, 8'h5A, 1, 3, 1, 5, 8'h3C, 8'hA5, 1, "split_read"};
    tbl[7]  = '{1, 7, 8'h11, 1, 5, 1, 7, 8'hA5, 8'h11, 1, "write_first_b"};
    tbl[8]  = '{0, 0, 8'h00, 1, 9, 1, 7, 8'h5A, 8'h11, 1, "rd_r9_r7"};
    tbl[9]  = '{1, 0, 8'h77, 1, 0, 0, 0, Z77, 8'h00, 0, "r0_wf_a"};
    tbl[10] = '{0, 0, 8'h00, 0, 0, 1, 0, Z77, Z77, 1, "r0_rdb"};
    tbl[11] = '{1, 0, 8'h66, 0, 0, 1, 0, Z77, Z66, 1, "r0_wf_b"};
    tbl[12] = '{0, 0, 8'h00, 1, 0, 0, 0, Z66, 8'h00, 0, "r0_rda"};

    step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, "reset");
    for (int i = 1; i <= 16; i++)
      if (i == 4) step(0, 1, 2, 8'hFF, 1, 2, 1, 2, 8'h00, 8'h00, 0, 0, "clear_ignores_traffic");
      else idle(8'h00, i == 16, "clear_ready");
    read_all_zero("cleared_zero");

    foreach (tbl[i])
      step(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ae, tbl[i].aa, tbl[i].be, tbl[i].ba,
           tbl[i].ea, tbl[i].eb, tbl[i].eo, 1, tbl[i].tag);

    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 8'(i + 1), 0, 0, 0, 0, Z66, 8'h00, 0, 1, "fill");
    for (int i = 0; i < 7; i++)
      step(0, 0, 0, 0, 1, 4'(i), 1, 4'(i), (ZR && i == 0) ? 8'h00 : 8'(i + 1),
           (ZR && i == 0) ? 8'h00 : 8'(i + 1), 1, 1, "fill_readback");
    step(1, 0, 0, 0, 1, 7, 1, 7, 8'h00, 8'h00, 0, 0, "reset_mid_run");
    for (int i = 1; i <= 8; i++) idle(8'h00, 0, "partial_clear");
    step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, "reset_mid_clear");
    for (int i = 1; i <= 16; i++) idle(8'h00, i == 16, "reclear_ready");
    read_all_zero("recleared_zero");

    @(negedge clk);
    check_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
